// File: rtl/riscv_pkg.sv
// Shared frontend types: reset PC, fetch FSM states and the IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } if_id_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues one imem request at a time, uses the
// BTB result to choose the next PC and delivers a registered IF/ID payload
// backed by a one-entry hold buffer. EX redirects flush and drop in-flight work.
module if_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0] redirect_pc,
  input  logic                      stall,
  output logic [riscv_pkg::XLEN-1:0] btb_pc_lookup,
  output logic                      btb_lookup_en,
  input  logic                      btb_hit,
  input  logic [riscv_pkg::XLEN-1:0] btb_target,
  output logic                      imem_req_valid,
  output logic [riscv_pkg::XLEN-1:0] imem_req_addr,
  input  logic                      imem_req_ready,
  input  logic                      imem_resp_valid,
  input  logic [riscv_pkg::ILEN-1:0] imem_resp_data,
  output logic                      if_id_valid,
  output logic [riscv_pkg::XLEN-1:0] if_id_pc,
  output logic [riscv_pkg::ILEN-1:0] if_id_instr,
  output logic                      if_id_pred_taken,
  output logic [riscv_pkg::XLEN-1:0] if_id_pred_target
);
  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          out_q, out_d;
  if_id_t          hold_q, hold_d;
  logic [XLEN-1:0] inf_pc_q, inf_pc_d;
  logic            inf_taken_q, inf_taken_d;
  logic [XLEN-1:0] inf_target_q, inf_target_d;

  logic   can_issue;
  logic   resp_live;
  logic   accept;
  if_id_t live;

  // Issue gating: no issue while the output is stalled or the hold buffer is full
  assign can_issue      = !hold_q.valid && !(out_q.valid && stall);
  assign resp_live      = (state_q == S_WAIT) && imem_resp_valid;
  assign imem_req_valid = ((state_q == S_REQ) || resp_live) && can_issue && !redirect_valid;
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_q;
  assign btb_pc_lookup  = pc_q;
  assign btb_lookup_en  = imem_req_valid;

  assign live = '{valid:       1'b1,
                  pc:          inf_pc_q,
                  instr:       imem_resp_data,
                  pred_taken:  inf_taken_q,
                  pred_target: inf_target_q};

  assign if_id_valid       = out_q.valid;
  assign if_id_pc          = out_q.pc;
  assign if_id_instr       = out_q.instr;
  assign if_id_pred_taken  = out_q.pred_taken;
  assign if_id_pred_target = out_q.pred_target;

  // Next-state, PC, in-flight capture, output register and hold buffer
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_d        = out_q;
    hold_d       = hold_q;
    inf_pc_d     = inf_pc_q;
    inf_taken_d  = inf_taken_q;
    inf_target_d = inf_target_q;

    if (accept) begin
      pc_d         = btb_target;
      inf_pc_d     = pc_q;
      inf_taken_d  = btb_hit;
      inf_target_d = btb_target;
    end

    // A live response parks in the hold buffer while the output is stalled
    if (resp_live && out_q.valid && stall) begin
      hold_d = live;
    end

    if (!stall || !out_q.valid) begin
      if (hold_q.valid) begin
        out_d        = hold_q;
        hold_d.valid = 1'b0;
      end else if (resp_live) begin
        out_d = live;
      end else begin
        out_d.valid = 1'b0;
      end
    end

    unique case (state_q)
      S_REQ:   if (accept) state_d = S_WAIT;
      S_WAIT:  if (imem_resp_valid) state_d = accept ? S_WAIT : S_REQ;
      S_DROP:  if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    // Redirect flushes everything; an outstanding request becomes a drop
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      out_d.valid  = 1'b0;
      hold_d.valid = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = S_REQ;
        S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      out_q        <= '0;
      hold_q       <= '0;
      inf_pc_q     <= '0;
      inf_taken_q  <= 1'b0;
      inf_target_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_q        <= out_d;
      hold_q       <= hold_d;
      inf_pc_q     <= inf_pc_d;
      inf_taken_q  <= inf_taken_d;
      inf_target_q <= inf_target_d;
    end
  end

  // Memory must never answer when nothing is outstanding
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!((state_q == S_REQ) && imem_resp_valid))
        else $error("if_stage: unsolicited imem response in S_REQ");
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small BTB model and a variable-latency
// single-outstanding instruction memory model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] btb_pc_lookup;
  logic        btb_lookup_en;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;

  int tests = 0;
  int fails = 0;

  // BTB model: single programmable hit entry, pc+4 otherwise
  logic        hit_en = 1'b0;
  logic [31:0] hit_pc = '0;
  logic [31:0] hit_tgt = '0;

  // Memory model
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int unsigned mem_cnt = 0;
  int unsigned mem_lat = 1;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .stall             (stall),
    .btb_pc_lookup     (btb_pc_lookup),
    .btb_lookup_en     (btb_lookup_en),
    .btb_hit           (btb_hit),
    .btb_target        (btb_target),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instr       (if_id_instr),
    .if_id_pred_taken  (if_id_pred_taken),
    .if_id_pred_target (if_id_pred_target)
  );

  always_comb begin
    btb_hit    = hit_en && (btb_pc_lookup == hit_pc);
    btb_target = btb_hit ? hit_tgt : btb_pc_lookup + 32'd4;
  end

  assign imem_resp_valid = mem_pend && (mem_cnt == 0);
  assign imem_resp_data  = mem_addr + 32'h1000_0000;

  always @(posedge clk) begin
    if (reset) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else begin
      if (imem_resp_valid) mem_pend <= 1'b0;
      else if (mem_pend && mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req_valid && imem_req_ready) begin
        mem_pend <= 1'b1;
        mem_addr <= imem_req_addr;
        mem_cnt  <= mem_lat - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and BTB hit entry 0x8 -> 0x40
    hit_en = 1'b1; hit_pc = 32'h8; hit_tgt = 32'h40;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_valid",   32'(if_id_valid), 32'h0);
    check("rst_req",     32'(imem_req_valid), 32'h1);
    check("rst_addr",    imem_req_addr, 32'h0);
    check("rst_btb_en",  32'(btb_lookup_en), 32'h1);
    check("rst_btb_pc",  btb_pc_lookup, 32'h0);

    // Streaming with 1-cycle memory
    tick();
    check("s1_valid", 32'(if_id_valid), 32'h0);
    check("s1_addr",  imem_req_addr, 32'h4);
    tick();
    check("s2_valid", 32'(if_id_valid), 32'h1);
    check("s2_pc",    if_id_pc, 32'h0);
    check("s2_instr", if_id_instr, 32'h1000_0000);
    check("s2_taken", 32'(if_id_pred_taken), 32'h0);
    check("s2_addr",  imem_req_addr, 32'h8);
    tick();
    check("s3_pc",    if_id_pc, 32'h4);
    check("s3_instr", if_id_instr, 32'h1000_0004);
    check("hit_addr", imem_req_addr, 32'h40);
    tick();
    check("hit_pc",     if_id_pc, 32'h8);
    check("hit_taken",  32'(if_id_pred_taken), 32'h1);
    check("hit_target", if_id_pred_target, 32'h40);
    check("hit_instr",  if_id_instr, 32'h1000_0008);
    tick();
    check("tgt_pc",     if_id_pc, 32'h40);
    check("tgt_taken",  32'(if_id_pred_taken), 32'h0);
    check("tgt_target", if_id_pred_target, 32'h44);

    // Reset mid-operation, then stall scenario
    reset = 1'b1; hit_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst2_valid", 32'(if_id_valid), 32'h0);
    check("rst2_addr",  imem_req_addr, 32'h0);
    tick();
    tick();
    check("st_pc0", if_id_pc, 32'h0);
    tick();
    check("st_pc4", if_id_pc, 32'h4);
    stall = 1'b1;
    #1;
    check("st_noreq0", 32'(imem_req_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_valid", 32'(if_id_valid), 32'h1);
      check("st_hold_pc",    if_id_pc, 32'h4);
      check("st_noreq",      32'(imem_req_valid), 32'h0);
    end
    stall = 1'b0;
    #1;
    check("st_drain_noreq", 32'(imem_req_valid), 32'h0);
    tick();
    check("st_pc8",    if_id_pc, 32'h8);
    check("st_instr8", if_id_instr, 32'h1000_0008);
    check("st_req",    32'(imem_req_valid), 32'h1);
    check("st_addrc",  imem_req_addr, 32'hC);
    tick();
    check("st_gap", 32'(if_id_valid), 32'h0);
    check("st_addr10", imem_req_addr, 32'h10);
    mem_lat = 3;
    tick();
    check("st_pcC_valid", 32'(if_id_valid), 32'h1);
    check("st_pcC", if_id_pc, 32'hC);

    // Redirect while waiting for 0x10
    check("rd_wait_noreq", 32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("rd_noreq", 32'(imem_req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rd_flush", 32'(if_id_valid), 32'h0);
    check("rd_drop_noreq", 32'(imem_req_valid), 32'h0);
    tick();
    check("rd_drop_resp", 32'(imem_resp_valid), 32'h1);
    check("rd_drop_noreq2", 32'(imem_req_valid), 32'h0);
    mem_lat = 1;
    tick();
    check("rd_dropped", 32'(if_id_valid), 32'h0);
    check("rd_req", 32'(imem_req_valid), 32'h1);
    check("rd_addr", imem_req_addr, 32'h100);
    tick();
    check("rd_dropped2", 32'(if_id_valid), 32'h0);
    check("rd_addr104", imem_req_addr, 32'h104);
    tick();
    check("rd_pc100", if_id_pc, 32'h100);
    check("rd_v100", 32'(if_id_valid), 32'h1);

    // Redirect coinciding with response and stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    check("rs_noreq", 32'(imem_req_valid), 32'h0);
    tick();
    check("rs_flush", 32'(if_id_valid), 32'h0);
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    check("rs_req", 32'(imem_req_valid), 32'h1);
    check("rs_addr", imem_req_addr, 32'h200);
    tick();
    check("rs_nohold", 32'(if_id_valid), 32'h0);
    tick();
    check("rs_pc200", if_id_pc, 32'h200);
    check("rs_instr", if_id_instr, 32'h1000_0200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the frontend. It owns the PC register and issues one instruction-memory request at a time. For each request it drives the BTB lookup port and consumes `hit`/`target_predicted` to pick the next PC, then delivers {pc, instr, prediction} to ID through a registered IF/ID output with a one-entry hold buffer. EX redirects (mispredict or exception target) flush the output and drop any in-flight response.

## Interface
- `RESET_PC`, default `riscv_pkg::RESET_PC` (32'h0000_0000): PC fetched first after reset.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `redirect_valid`  in  1  EX redirect request; highest priority.
- `redirect_pc`  in  XLEN  new fetch PC on redirect.
- `stall`  in  1  ID not accepting; the output is held.
- `btb_pc_lookup`  out  XLEN  equals `pc_q`.
- `btb_lookup_en`  out  1  equals `imem_req_valid`.
- `btb_hit`  in  1  BTB hit for `btb_pc_lookup`.
- `btb_target`  in  XLEN  BTB predicted next PC; the BTB supplies pc+4 on a miss.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  XLEN  equals `pc_q`.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  response valid; arrives in order, at least 1 cycle after accept.
- `imem_resp_data`  in  32  instruction word.
- `if_id_valid`, `if_id_pc`, `if_id_instr`, `if_id_pred_taken`, `if_id_pred_target`  out  1/XLEN/32/1/XLEN  registered IF/ID payload.

## Operation
- **States:**
  - S_REQ: ready to issue.
  - S_WAIT: one request outstanding.
  - S_DROP: one request outstanding; its response is discarded.
- **Issue and prediction:**
  - `can_issue` = !hold_valid && !(if_id_valid && stall).
  - `imem_req_valid` = (S_REQ || (S_WAIT && imem_resp_valid)) && can_issue && !redirect_valid.
  - On accept (valid && ready): `pc_q <= btb_target`. Capture into in-flight regs: pc = `pc_q`, pred_taken = `btb_hit`, pred_target = `btb_target`. Next state is S_WAIT.
- **Response in S_WAIT:**
  - The response plus the in-flight regs form the payload.
  - If `if_id_valid && stall`, the payload goes to the hold buffer. Otherwise it loads the IF/ID output.
  - If no new request is accepted that cycle, next state is S_REQ.
- **Output update:** occurs when !stall || !if_id_valid. The source is the hold buffer if `hold_valid` (which then clears), else a live response, else `if_id_valid <= 0`.
- **Redirect** (any state, overrides everything else that cycle):
  - `pc_q <= redirect_pc`; `if_id_valid <= 0`; `hold_valid <= 0`; no request issued.
  - From S_WAIT with no response that cycle, go to S_DROP. From S_WAIT with a response that cycle, discard it and go to S_REQ.
  - From S_DROP, stay in S_DROP, or go to S_REQ if a response arrives that cycle.
  - From S_REQ, stay in S_REQ.
- **S_DROP:** the next response is discarded, then go to S_REQ. No issue is allowed in S_DROP.
- **Arithmetic:** PC arithmetic lives in the BTB. This block never adds. `pc_q[1:0]` is passed through unchanged.

## Timing
- **Reset values:**
  - state = S_REQ, `pc_q` = RESET_PC, `hold_valid` = 0.
  - All `if_id_*` = 0, so `imem_req_valid` is high in the first cycle after reset deasserts.
- **Latency:** for accept at cycle N and response at cycle M ≥ N+1, `if_id_valid` is high at M+1 (absent stall).
- **Throughput:** with a 1-cycle memory, back-to-back issue in S_WAIT gives 1 instr/cycle.
- **Stall:** the output holds stable while `stall && if_id_valid`. At most one further instruction is buffered. Issue halts until the hold buffer drains.
- **Reset mid-operation:** wins over redirect. An outstanding response arriving after reset is treated as unsolicited and ignored in S_REQ. The memory must also be reset.
- **Protocol error:** `imem_resp_valid` in S_REQ is ignored; add an assertion.

## Structure
- In `riscv_pkg`: `RESET_PC`; `fetch_state_t` enum {S_REQ, S_WAIT, S_DROP}; `if_id_t` packed struct {valid, pc, instr, pred_taken, pred_target}.
- The output register and the hold buffer both use `if_id_t`.
- No sub-module. The `btb` instance lives beside this block in the frontend top, wired to the `btb_*` ports.

## Test plan
- **Reset:** reset with RESET_PC=0 -> request at 0x0 the first cycle after reset; no `if_id_valid` before the first response.
- **Streaming, BTB miss:** 1-cycle memory, btb_target=pc+4 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; `if_id_pc` 0x0, 0x4, 0x8 on consecutive cycles with pred_taken=0.
- **BTB hit:** at pc 0x8, btb_hit=1, target=0x40 -> next request 0x40; output for 0x8 has pred_taken=1, pred_target=0x40.
- **Stall:** stall held 3 cycles with output valid at 0x4 -> output stays 0x4; 0x8 captured in hold; no new request; after release, 0x8 then 0xC delivered in order.
- **Redirect mid-flight:** redirect_pc=0x100 while S_WAIT for 0x10 -> `if_id_valid`=0 next cycle; 0x10 response dropped; next request 0x100.
- **Redirect with response and stall:** redirect on the same cycle as a response and as stall -> the response is discarded, `hold_valid`=0, next request is redirect_pc.
